// File: rtl/la_pkg.sv
// Shared constants and types for the logic-analyzer frame multiplexer.
package la_pkg;
  localparam logic [3:0] LA_HDR_TAG   = 4'hA;
  localparam int         LA_UART_BITS = 10;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    SEND
  } frame_state_e;
endpackage

// File: rtl/la_frame_mux_uart_tx_byte.sv
// 8N1 byte transmitter; accepts a new byte while idle or in the last cycle of
// the current stop bit, so consecutive bytes leave no gap on the line.
module uart_tx_byte
  import la_pkg::*;
#(
  parameter int BAUD_PRESCALER = 434
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] byte_dat,
  input  logic       byte_vld,
  output logic       byte_rdy,
  output logic       tx
);
  localparam int CNT_W = $clog2(BAUD_PRESCALER);

  logic             active_q, active_d;
  logic [9:0]       shift_q, shift_d;
  logic [3:0]       bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
  logic             last_tick, bit_end, byte_end;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      active_q   <= 1'b0;
      shift_q    <= '1;
      bit_idx_q  <= '0;
      baud_cnt_q <= '0;
    end else begin
      active_q   <= active_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      baud_cnt_q <= baud_cnt_d;
    end
  end

  assign last_tick = (baud_cnt_q == CNT_W'(BAUD_PRESCALER - 1));
  assign bit_end   = active_q && last_tick;
  assign byte_end  = bit_end && (bit_idx_q == 4'(LA_UART_BITS - 1));
  assign byte_rdy  = !active_q || byte_end;

  always_comb begin
    active_d   = active_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    baud_cnt_d = baud_cnt_q;
    if (active_q) begin
      baud_cnt_d = last_tick ? '0 : baud_cnt_q + 1'b1;
      if (bit_end) begin
        shift_d   = {1'b1, shift_q[9:1]};
        bit_idx_d = bit_idx_q + 4'd1;
      end
      if (byte_end) begin
        active_d = 1'b0;
      end
    end
    // Shift register carries {stop, data LSB-first, start}; bit 0 is on the line.
    if (byte_vld && byte_rdy) begin
      active_d   = 1'b1;
      shift_d    = {1'b1, byte_dat, 1'b0};
      bit_idx_d  = '0;
      baud_cnt_d = '0;
    end
  end

  assign tx = active_q ? shift_q[0] : 1'b1;
endmodule

// File: rtl/la_frame_mux.sv
// Round-robin channel arbiter that frames one popped word as UART bytes:
// header {A,k}, data MSB-first, plus XOR checksum when LA_FRAME_CHECKSUM_EN is defined.
module la_frame_mux
  import la_pkg::*;
#(
  parameter int CH_NO          = 4,
  parameter int DATA_W         = 32,
  parameter int BAUD_PRESCALER = 434
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [CH_NO*DATA_W-1:0] data,
  input  logic [CH_NO-1:0]        availables,
  output logic [CH_NO-1:0]        reads,
  output logic                    tx,
  output logic                    busy,
  output logic                    frame_done
);
  localparam int DATA_BYTES = DATA_W / 8;
`ifdef LA_FRAME_CHECKSUM_EN
  localparam int N_BYTES = DATA_BYTES + 2;
`else
  localparam int N_BYTES = DATA_BYTES + 1;
`endif

  frame_state_e      state_q, state_d;
  logic [3:0]        ptr_q, ptr_d;
  logic [3:0]        sel_q, sel_d;
  logic [3:0]        byte_idx_q, byte_idx_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic              frame_done_q, frame_done_d;

  logic              grant_found;
  logic [3:0]        grant_idx;
  logic [CH_NO-1:0]  avail_shift;
  int                cand;

  logic [7:0]        hdr;
  logic [7:0]        byte_dat;
  logic              byte_vld, byte_rdy;
  logic              last_byte;

`ifdef LA_FRAME_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
  logic              next_is_data;
`endif

  // First requesting channel at or after the round-robin pointer.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    avail_shift = '0;
    for (int i = 0; i < CH_NO; i++) begin
      cand        = (int'(ptr_q) + i) % CH_NO;
      avail_shift = availables >> cand;
      if (!grant_found && avail_shift[0]) begin
        grant_found = 1'b1;
        grant_idx   = 4'(cand);
      end
    end
  end

  assign hdr       = {LA_HDR_TAG, sel_q};
  assign last_byte = (byte_idx_q == 4'(N_BYTES - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_found) state_d = GRANT;
      GRANT:   state_d = SEND;
      SEND:    if (byte_rdy && last_byte) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    reads    = '0;
    byte_vld = 1'b0;
    byte_dat = hdr;
    for (int k = 0; k < CH_NO; k++) begin
      reads[k] = (state_q == GRANT) && (sel_q == 4'(k));
    end
    if (state_q == GRANT) begin
      byte_vld = 1'b1;
    end else if (state_q == SEND && byte_rdy && !last_byte) begin
      byte_vld = 1'b1;
`ifdef LA_FRAME_CHECKSUM_EN
      byte_dat = next_is_data ? word_q[DATA_W-1 -: 8] : csum_q;
`else
      byte_dat = word_q[DATA_W-1 -: 8];
`endif
    end
  end

  assign busy       = (state_q != IDLE);
  assign frame_done = frame_done_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ptr_q        <= '0;
      sel_q        <= '0;
      byte_idx_q   <= '0;
      word_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      ptr_q        <= ptr_d;
      sel_q        <= sel_d;
      byte_idx_q   <= byte_idx_d;
      word_q       <= word_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    ptr_d        = ptr_q;
    sel_d        = sel_q;
    byte_idx_d   = byte_idx_q;
    word_d       = word_q;
    frame_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_found) sel_d = grant_idx;
      end
      GRANT: begin
        word_d     = DATA_W'(data >> (int'(sel_q) * DATA_W));
        ptr_d      = (sel_q == 4'(CH_NO - 1)) ? 4'd0 : sel_q + 4'd1;
        byte_idx_d = '0;
      end
      SEND: begin
        // Word drains MSB byte first by shifting left after each accepted data byte.
        if (byte_rdy) begin
          if (last_byte) begin
            frame_done_d = 1'b1;
          end else begin
            byte_idx_d = byte_idx_q + 4'd1;
            word_d     = word_q << 8;
          end
        end
      end
      default: ;
    endcase
  end

`ifdef LA_FRAME_CHECKSUM_EN
  assign next_is_data = (byte_idx_q < 4'(DATA_BYTES));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  always_comb begin
    csum_d = csum_q;
    if (state_q == GRANT) begin
      csum_d = hdr;
    end else if (state_q == SEND && byte_rdy && !last_byte && next_is_data) begin
      csum_d = csum_q ^ word_q[DATA_W-1 -: 8];
    end
  end
`endif

  uart_tx_byte #(
    .BAUD_PRESCALER(BAUD_PRESCALER)
  ) u_uart (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .byte_dat(byte_dat),
    .byte_vld(byte_vld),
    .byte_rdy(byte_rdy),
    .tx      (tx)
  );
endmodule

// File: tb/tb_la_frame_mux.sv
// Scoreboard bench: channel-queue model predicts grant order and frame bytes;
// a UART receiver monitor decodes tx and compares against the expected queues.
module tb_la_frame_mux;
  localparam int CH_NO  = 4;
  localparam int DATA_W = 32;
  localparam int BAUD   = 4;
  localparam int NB     = DATA_W / 8;
`ifdef LA_FRAME_CHECKSUM_EN
  localparam int N = NB + 2;
`else
  localparam int N = NB + 1;
`endif

  logic                    i_clk = 1'b0;
  logic                    i_rst;
  logic [CH_NO*DATA_W-1:0] data;
  logic [CH_NO-1:0]        availables;
  logic [CH_NO-1:0]        reads;
  logic                    tx, busy, frame_done;

  la_frame_mux #(.CH_NO(CH_NO), .DATA_W(DATA_W), .BAUD_PRESCALER(BAUD)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .data(data), .availables(availables),
    .reads(reads), .tx(tx), .busy(busy), .frame_done(frame_done)
  );

  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad   = 0;

  logic [DATA_W-1:0] chw [CH_NO][4];
  int                chcnt [CH_NO];
  logic [7:0]        exp_bytes[$];
  int                exp_ch[$];
  int                mptr = 0;

  // Monitor state, shared for reset-test synchronisation.
  int         cyc = 0;
  int         rx_active = 0;
  int         rx_cnt = 0;
  logic [9:0] rx_bits;
  int         fr_bytes = 0;
  int         fr_start = 0;
  int         last_done = -100;

  function automatic void check(string name, longint act, longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void refresh();
    for (int k = 0; k < CH_NO; k++) begin
      availables[k] = (chcnt[k] > 0);
      data[k*DATA_W +: DATA_W] = (chcnt[k] > 0) ? chw[k][0] : '0;
    end
  endfunction

  function automatic void post(int k, logic [DATA_W-1:0] w);
    chw[k][chcnt[k]] = w;
    chcnt[k]++;
  endfunction

  // Reference: serve pending channels in round-robin order, one word per frame.
  function automatic void model_batch();
    int          used [CH_NO];
    int          k;
    bit          any;
    logic [7:0]  h, cs;
    logic [DATA_W-1:0] w;
    for (int i = 0; i < CH_NO; i++) used[i] = 0;
    do begin
      any = 0;
      k   = 0;
      for (int i = 0; i < CH_NO; i++) begin
        int c;
        c = (mptr + i) % CH_NO;
        if (!any && used[c] < chcnt[c]) begin
          any = 1;
          k   = c;
        end
      end
      if (any) begin
        exp_ch.push_back(k);
        h  = 8'hA0 + 8'(k);
        cs = h;
        exp_bytes.push_back(h);
        w = chw[k][used[k]];
        for (int j = 0; j < NB; j++) begin
          exp_bytes.push_back(w[DATA_W-1 -: 8]);
          cs = cs ^ w[DATA_W-1 -: 8];
          w  = w << 8;
        end
`ifdef LA_FRAME_CHECKSUM_EN
        exp_bytes.push_back(cs);
`endif
        used[k]++;
        mptr = (k + 1) % CH_NO;
      end
    end while (any);
  endfunction

  // Channel side: pop on a read strobe after the DUT has latched the word.
  initial begin
    int k;
    forever begin
      @(negedge i_clk);
      if (!i_rst && reads != '0) begin
        check("reads_onehot", $countones(reads), 1);
        k = 0;
        for (int i = 0; i < CH_NO; i++) if (reads[i]) k = i;
        if (exp_ch.size() == 0) begin
          check("read_unexpected", k, -1);
        end else begin
          check("read_channel", k, exp_ch.pop_front());
        end
        @(posedge i_clk);
        #1;
        if (chcnt[k] > 0) begin
          for (int j = 0; j < 3; j++) chw[k][j] = chw[k][j+1];
          chcnt[k]--;
        end
        refresh();
      end
    end
  end

  // UART receiver and frame checker.
  always @(negedge i_clk) begin
    cyc++;
    if (i_rst) begin
      rx_active = 0;
      fr_bytes  = 0;
    end else begin
      if (frame_done) begin
        check("frame_bytes", fr_bytes, N);
        check("frame_cycles", cyc - fr_start, 10 * N * BAUD);
        check("busy_at_done", busy, 0);
        fr_bytes  = 0;
        last_done = cyc;
      end
      if (rx_active == 0) begin
        if (tx == 1'b0) begin
          rx_active = 1;
          rx_cnt    = 0;
          if (fr_bytes == 0) begin
            fr_start = cyc;
            check("idle_gap_ge2", (cyc - last_done) >= 2, 1);
            check("busy_in_frame", busy, 1);
          end
        end
      end else begin
        rx_cnt++;
      end
      if (rx_active != 0 && (rx_cnt % BAUD) == BAUD / 2) begin
        rx_bits[rx_cnt / BAUD] = tx;
        if (rx_cnt / BAUD == 9) begin
          rx_active = 0;
          check("start_bit", rx_bits[0], 0);
          check("stop_bit", rx_bits[9], 1);
          if (exp_bytes.size() == 0) begin
            check("byte_unexpected", rx_bits[8:1], 16'hFFFF);
          end else begin
            check("frame_byte", rx_bits[8:1], exp_bytes.pop_front());
          end
          fr_bytes++;
        end
      end
    end
  end

  task automatic wait_idle(string name);
    int n;
    bit ok;
    n  = 0;
    ok = 0;
    while (n < 20000 && !ok) begin
      @(negedge i_clk);
      n++;
      ok = (exp_bytes.size() == 0) && !busy;
      for (int k = 0; k < CH_NO; k++) if (chcnt[k] != 0) ok = 0;
    end
    if (!ok) check({name, "_timeout"}, 0, 1);
    @(negedge i_clk);
  endtask

  initial begin
    logic [DATA_W-1:0] w;
    int n;
    i_rst      = 1'b1;
    availables = '0;
    data       = '0;
    for (int k = 0; k < CH_NO; k++) chcnt[k] = 0;
    #1;
    check("rst_tx", tx, 1);
    check("rst_reads", reads, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    repeat (2) @(negedge i_clk);

    // Channel 2 alone: read strobe one cycle later, start bit the cycle after.
    check("reads_before", reads, 0);
    post(2, 32'hDEADBEEF);
    model_batch();
    refresh();
    @(negedge i_clk);
    check("reads_timing", reads, 4'b0100);
    check("tx_idle_in_grant", tx, 1);
    @(negedge i_clk);
    check("start_after_grant", tx, 0);
    check("reads_single_cycle", reads, 0);
    wait_idle("directed_ch2");

    // Pointer at 2 after serving channel 1; then channels 0 and 3 compete.
    post(1, DATA_W'($urandom()));
    model_batch();
    refresh();
    wait_idle("ch1");
    post(0, DATA_W'($urandom()));
    post(3, DATA_W'($urandom()));
    model_batch();
    refresh();
    wait_idle("ptr2_ch0_ch3");

    // Reset during the third byte of a frame.
    post(1, DATA_W'($urandom()));
    model_batch();
    refresh();
    n = 0;
    while (n < 5000 && !(fr_bytes == 2 && rx_active != 0)) begin
      @(negedge i_clk);
      n++;
    end
    if (n >= 5000) check("third_byte_timeout", 0, 1);
    @(posedge i_clk);
    #2;
    i_rst = 1'b1;
    #1;
    check("midrst_tx", tx, 1);
    check("midrst_reads", reads, 0);
    check("midrst_busy", busy, 0);
    exp_bytes.delete();
    exp_ch.delete();
    mptr = 0;
    repeat (3) begin
      @(negedge i_clk);
      check("midrst_reads_held", reads, 0);
    end
    i_rst = 1'b0;
    repeat (3) begin
      @(negedge i_clk);
      check("no_read_after_rst", reads, 0);
    end

    // All channels pending; channel 0 holds two words -> 0,1,2,3,0.
    for (int k = 0; k < CH_NO; k++) post(k, DATA_W'($urandom()));
    post(0, DATA_W'($urandom()));
    model_batch();
    refresh();
    wait_idle("all_four");

    for (int b = 0; b < 8; b++) begin
      int mask;
      mask = $urandom_range(1, (1 << CH_NO) - 1);
      for (int k = 0; k < CH_NO; k++) begin
        if (mask[k]) begin
          int c;
          c = $urandom_range(1, 2);
          for (int j = 0; j < c; j++) begin
            w = DATA_W'({$urandom(), $urandom()});
            post(k, w);
          end
        end
      end
      model_batch();
      refresh();
      wait_idle("random_batch");
    end

    check("exp_bytes_left", exp_bytes.size(), 0);
    check("exp_reads_left", exp_ch.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/la_frame_mux.md
# la_frame_mux

Parametrised successor to the analyzer's channel-to-UART transfer stage. It arbitrates round-robin among CH_NO capture channels and pops one word from a ready channel. It wraps that word in a framed packet (header byte with channel index, data bytes MSB-first, optional checksum) and shifts it out as 8N1 UART on `tx`. It sits between the per-port capture channels and the board's serial pin.

## Interface
- CH_NO, 4, number of channels; legal 1..16
- DATA_W, 32, word width per channel; multiple of 8, legal 8..64
- BAUD_PRESCALER, 434, clocks per UART bit; legal ≥2
- i_clk  input  1  sole clock; everything rising-edge
- i_rst  input  1  reset, asynchronous, active-high
- data  input  CH_NO*DATA_W  channel k word at [k*DATA_W +: DATA_W]; valid while availables[k]=1
- availables  input  CH_NO  channel k holds a word
- reads  output  CH_NO  one-cycle pop strobe, at most one bit set
- tx  output  1  UART line, idle high
- busy  output  1  frame in progress
- frame_done  output  1  one-cycle pulse after stop bit of a frame's last byte

## Operation
- Reset values: tx=1, reads=0, busy=0, frame_done=0, rr pointer=0, state=IDLE.
- States: IDLE → GRANT → SEND → IDLE.
- IDLE: if any availables bit is set, choose the first set index k scanning ptr, ptr+1, …, CH_NO-1, 0, …, ptr-1. Go to GRANT.
- GRANT, one cycle: reads[k]=1; latch data slice k into word register; latch hdr = {4'hA, k[3:0]}; ptr ← (k+1) mod CH_NO; busy=1; go to SEND.
- SEND: bytes in order: hdr, then word bytes from [DATA_W-1 -: 8] down to [7:0], then checksum if enabled. N = 1 + DATA_W/8 (+1).
- Each byte: start bit 0, 8 data bits LSB-first, stop bit 1. Each bit lasts exactly BAUD_PRESCALER clocks. Consecutive bytes have no gap.
- Last stop bit completes: frame_done=1 for one cycle, busy=0, return to IDLE.
- availables changing during SEND is ignored. The word is already latched.
- availables deasserted in the grant decision cycle: still sampled in IDLE. GRANT pops whatever was selected, and the channel must tolerate it (channel contract: available is held until read).
- Baud counter width $clog2(BAUD_PRESCALER); counts 0..BAUD_PRESCALER-1 and wraps. Bit index 0..9; byte index 0..N-1.

## Timing
- availables[k] rises in IDLE → reads[k] high the next cycle (GRANT) → start bit on tx the cycle after.
- Frame duration 10·N·BAUD_PRESCALER clocks from start-bit first cycle to stop-bit end.
- Back-to-back frames: at least 2 cycles of tx=1 beyond the final stop bit (frame_done cycle in IDLE, then GRANT).
- i_rst asserted mid-frame: tx=1, reads=0 immediately (async). Partial frame is abandoned and the latched word is lost. ptr returns to 0.
- Simultaneous availables: lowest index at/after ptr wins. Every requesting channel is served within CH_NO frames.

## Configuration
- LA_FRAME_CHECKSUM_EN defined: a trailing byte equal to the XOR of the header and all data bytes is appended; N = 2 + DATA_W/8.
- LA_FRAME_CHECKSUM_EN undefined: no trailing byte; N = 1 + DATA_W/8. The XOR accumulator is not built.

## Structure
- Package la_pkg holds: header nibble constant LA_HDR_TAG=4'hA, frame state enum (IDLE, GRANT, SEND), UART bit count constant 10.
- One sub-module, uart_tx_byte: byte in, valid/ready handshake, BAUD_PRESCALER parameter, drives tx; ready high in the cycle its stop bit ends.
- The top holds the arbiter, word/header latch, byte sequencer and optional checksum.

## Test plan
- CH_NO=4, DATA_W=32, BAUD_PRESCALER=4, checksum off. Channel 2 presents 0xDEADBEEF.
  - reads=4'b0100 exactly one cycle after availables[2].
  - tx carries bytes A2 DE AD BE EF, each 40 clocks.
  - frame_done pulses once.
- availables=4'b1111 held for 4 frames from reset → headers A0, A1, A2, A3 in order. A 5th frame gives A0.
- ptr=2, only channels 0 and 3 requesting → channel 3 served first, then channel 0.
- LA_FRAME_CHECKSUM_EN, channel 1 with 0x01020304 → bytes A1 01 02 03 04, checksum A5.
- i_rst pulsed during the third byte → tx=1 within the same cycle, no further reads. After release, the next grant starts from channel 0.
- DATA_W=8, CH_NO=1, BAUD_PRESCALER=2, word 0x55 → 2-byte frame A0 55 of 40 clocks; reads pulses once per available.
